// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the parametrised floating-point datapath blocks.
//   - fp_class_e     : operand classification (subnormals fold into ZERO)
//   - fp_bias        : exponent bias for a given exponent width
//   - fp_classify    : width-independent classifier from field summary bits
//   - fp_qnan/fp_inf : canonical quiet NaN / signed infinity encodings,
//                      returned right-aligned in 64 bits for any EXP_W/MAN_W
//   - FLAG_*         : bit positions of the optional exception-flag vector
// -----------------------------------------------------------------------------
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Subnormals (exp == 0, frac != 0) are deliberately reported as ZERO.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return ZERO;
    if (exp_ones) return frac_zero ? INF : NAN;
    return NORM;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_inf(input logic sign, input int exp_w,
                                         input int man_w);
    return ({63'd0, sign} << (exp_w + man_w)) |
           (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
// Combinational normalise / round-to-nearest-even / pack stage. Takes a raw
// mantissa product of two hidden-bit-normalised significands (value in [1,4))
// and a signed pre-normalisation biased exponent, and produces the packed
// result, saturating to signed infinity or flushing to signed zero.
//
// Optional build macro FP_MUL_FLAGS_EN exposes overflow/underflow/inexact.
//
// Ports:
//   i_sign      result sign
//   i_exp       signed biased exponent before normalisation (EXP_W+2 bits)
//   i_prod      mantissa product, 2*MAN_W+2 bits, bit 2*MAN_W is 1 or MSB is 1
//   o_result    packed {sign, exp, frac}
//   o_overflow  (flags build) result saturated to infinity
//   o_underflow (flags build) result flushed to zero
//   o_inexact   (flags build) discarded bits nonzero, or over/underflow
// -----------------------------------------------------------------------------
module fp_round_pack
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1,
  localparam int XW    = EXP_W + 2,
  localparam int PW    = 2 * MAN_W + 2
) (
  input  logic                 i_sign,
  input  logic signed [XW-1:0] i_exp,
  input  logic        [PW-1:0] i_prod,
  output logic        [W-1:0]  o_result
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_inexact
`endif
);

  localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic        [MAN_W-1:0] w_frac;
  logic                    w_guard;
  logic                    w_sticky;
  logic                    w_rnd;
  logic        [MAN_W:0]   w_frac_sum;
  logic signed [XW-1:0]    w_exp_n;
  logic signed [XW-1:0]    w_exp_f;
  logic                    w_ovf;
  logic                    w_unf;

  always_comb begin
    // Product in [2,4): drop one more bit and bump the exponent.
    if (i_prod[PW-1]) begin
      w_frac   = i_prod[PW-2:MAN_W+1];
      w_guard  = i_prod[MAN_W];
      w_sticky = |i_prod[MAN_W-1:0];
      w_exp_n  = i_exp + XW'(1);
    end else begin
      w_frac   = i_prod[PW-3:MAN_W];
      w_guard  = i_prod[MAN_W-1];
      w_sticky = |i_prod[MAN_W-2:0];
      w_exp_n  = i_exp;
    end

    w_rnd      = w_guard & (w_sticky | w_frac[0]);
    // A carry out of the fraction means 1.111..1 rounded to 10.000..0:
    // fraction becomes zero and the exponent absorbs the carry.
    w_frac_sum = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_rnd};
    w_exp_f    = w_exp_n + {{(XW-1){1'b0}}, w_frac_sum[MAN_W]};

    w_ovf      = (w_exp_f >= EXP_INF);
    w_unf      = (w_exp_f <= EXP_ZERO);

    o_result   = {i_sign, w_exp_f[EXP_W-1:0], w_frac_sum[MAN_W-1:0]};
    if (w_ovf) begin
      o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      o_result = {i_sign, {(W-1){1'b0}}};
    end
  end

`ifdef FP_MUL_FLAGS_EN
  assign o_overflow  = w_ovf;
  assign o_underflow = w_unf;
  assign o_inexact   = w_guard | w_sticky | w_ovf | w_unf;
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Three-stage pipelined IEEE-754-style multiplier with generic exponent and
// fraction widths, round-to-nearest-even, subnormal flush-to-zero and full
// special-value handling. One global enable stalls every stage together;
// bubbles are carried, not squeezed out.
//
// Optional build macro FP_MUL_FLAGS_EN adds the flags output
// {invalid, overflow, underflow, inexact}, registered with result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (drops all in-flight ops)
//   in_valid   operand pair valid
//   in_ready   operands accepted this cycle (= pipeline enable)
//   a, b       operands {sign, exp, frac}
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     product
//   flags      (flags build) exception flags for result
// -----------------------------------------------------------------------------
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  localparam int XW = EXP_W + 2;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;

  localparam logic signed [XW-1:0] BIAS_X  = XW'(fp_bias(EXP_W));
  localparam logic [63:0]          QNAN_64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0]          INF_64  = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN    = QNAN_64[W-1:0];
  localparam logic [W-2:0]         INF_MAG = INF_64[W-2:0];

  logic w_en;
  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  // ---- stage 1: unpack, classify, sign, exponent sum ----
  logic                    w_sa, w_sb;
  logic        [EXP_W-1:0] w_ea, w_eb;
  logic        [MAN_W-1:0] w_fa, w_fb;
  fp_class_e               w_ca, w_cb;
  logic signed [XW-1:0]    w_esum;

  assign {w_sa, w_ea, w_fa} = a;
  assign {w_sb, w_eb, w_fb} = b;
  assign w_ca   = fp_classify(w_ea == '0, &w_ea, w_fa == '0);
  assign w_cb   = fp_classify(w_eb == '0, &w_eb, w_fb == '0);
  assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_X;

  logic                 r_vld_p1;
  logic                 r_sign_p1;
  fp_class_e            r_ca_p1, r_cb_p1;
  logic signed [XW-1:0] r_exp_p1;
  logic        [MW-1:0] r_ma_p1, r_mb_p1;

  // ---- stage 2: significand product ----
  logic                 r_vld_p2;
  logic                 r_sign_p2;
  fp_class_e            r_ca_p2, r_cb_p2;
  logic signed [XW-1:0] r_exp_p2;
  logic        [PW-1:0] r_prod_p2;

  always_ff @(posedge clk) begin
    if (w_en) begin
      if (in_valid) begin
        r_sign_p1 <= w_sa ^ w_sb;
        r_ca_p1   <= w_ca;
        r_cb_p1   <= w_cb;
        r_exp_p1  <= w_esum;
        r_ma_p1   <= {1'b1, w_fa};
        r_mb_p1   <= {1'b1, w_fb};
      end
      if (r_vld_p1) begin
        r_sign_p2 <= r_sign_p1;
        r_ca_p2   <= r_ca_p1;
        r_cb_p2   <= r_cb_p1;
        r_exp_p2  <= r_exp_p1;
        r_prod_p2 <= PW'(r_ma_p1) * PW'(r_mb_p1);
      end
    end
  end

  // ---- stage 3: normalise, round, special-value override, pack ----
  logic [W-1:0] w_rp_result;
  logic         w_nan, w_inf, w_zero;
  logic [W-1:0] w_res;

`ifdef FP_MUL_FLAGS_EN
  logic       w_rp_ovf, w_rp_unf, w_rp_inx;
  logic [3:0] w_flg;
`endif

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_sign      (r_sign_p2),
    .i_exp       (r_exp_p2),
    .i_prod      (r_prod_p2),
    .o_result    (w_rp_result)
`ifdef FP_MUL_FLAGS_EN
    ,
    .o_overflow  (w_rp_ovf),
    .o_underflow (w_rp_unf),
    .o_inexact   (w_rp_inx)
`endif
  );

  assign w_nan  = (r_ca_p2 == NAN) || (r_cb_p2 == NAN) ||
                  (r_ca_p2 == INF && r_cb_p2 == ZERO) ||
                  (r_ca_p2 == ZERO && r_cb_p2 == INF);
  assign w_inf  = (r_ca_p2 == INF) || (r_cb_p2 == INF);
  assign w_zero = (r_ca_p2 == ZERO) || (r_cb_p2 == ZERO);

  // Special values in priority order; the rounded path only for NORM x NORM.
  always_comb begin
    w_res = w_rp_result;
`ifdef FP_MUL_FLAGS_EN
    w_flg = {1'b0, w_rp_ovf, w_rp_unf, w_rp_inx};
`endif
    if (w_nan) begin
      w_res = QNAN;
`ifdef FP_MUL_FLAGS_EN
      w_flg               = '0;
      w_flg[FLAG_INVALID] = 1'b1;
`endif
    end else if (w_inf) begin
      w_res = {r_sign_p2, INF_MAG};
`ifdef FP_MUL_FLAGS_EN
      w_flg = '0;
`endif
    end else if (w_zero) begin
      w_res = {r_sign_p2, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      w_flg = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_vld_p2  <= r_vld_p1;
      out_valid <= r_vld_p2;
      if (r_vld_p2) begin
        result <= w_res;
      end
    end
  end

`ifdef FP_MUL_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (w_en && r_vld_p2) begin
      flags <= w_flg;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // FP32 instance
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  // Half-precision instance
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  h_flags;
`endif

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef FP_MUL_FLAGS_EN
    , .flags(flags)
`endif
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result)
`ifdef FP_MUL_FLAGS_EN
    , .flags(h_flags)
`endif
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   pushes  = 0;
  int   pops    = 0;
  int   dropped = 0;

  // Consumer backpressure: fixed level or random per cycle.
  logic rand_bp = 1'b0;
  logic bp_val  = 1'b1;
  logic r_rand  = 1'b1;
  always @(negedge clk) r_rand = ($urandom_range(0, 3) != 0);
  assign out_ready = rand_bp ? r_rand : bp_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact product P * 2^e, then round the real value to MAN_W+1
  // significant bits by comparing the dropped remainder against one half ulp.
  function automatic logic [31:0] ref_mul(input int ew, input int mw, input logic [31:0] x,
                                          input logic [31:0] y, output logic [3:0] fl);
    longint emax, bias, fmask, xv, yv, sgn, ex, ey, fx, fy, p, keep, rem, half, e, be, res;
    int     k, sh;
    logic   nx, ny, ix, iy, zx, zy;
    emax  = (longint'(1) << ew) - 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    fmask = (longint'(1) << mw) - 1;
    xv    = longint'({32'd0, x});
    yv    = longint'({32'd0, y});
    sgn   = ((xv >> (ew + mw)) ^ (yv >> (ew + mw))) & 1;
    ex = (xv >> mw) & emax;  fx = xv & fmask;
    ey = (yv >> mw) & emax;  fy = yv & fmask;
    nx = (ex == emax) && (fx != 0);  ix = (ex == emax) && (fx == 0);  zx = (ex == 0);
    ny = (ey == emax) && (fy != 0);  iy = (ey == emax) && (fy == 0);  zy = (ey == 0);
    fl = 4'b0000;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      res = (emax << mw) | (longint'(1) << (mw - 1));
      fl  = 4'b1000;
    end else if (ix || iy) begin
      res = (sgn << (ew + mw)) | (emax << mw);
    end else if (zx || zy) begin
      res = sgn << (ew + mw);
    end else begin
      p = ((longint'(1) << mw) + fx) * ((longint'(1) << mw) + fy);
      k = 0;
      while ((p >> (k + 1)) != 0) k++;
      sh   = k - mw;
      keep = p >> sh;
      rem  = p & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (keep & 1) == 1)) keep++;
      e = (ex - bias) + (ey - bias) + (k - 2 * mw);
      if (keep == (longint'(2) << mw)) begin
        keep = keep >> 1;
        e++;
      end
      be = e + bias;
      if (be >= emax) begin
        res = (sgn << (ew + mw)) | (emax << mw);
        fl  = 4'b0101;
      end else if (be <= 0) begin
        res = sgn << (ew + mw);
        fl  = 4'b0011;
      end else begin
        res = (sgn << (ew + mw)) | (be << mw) | (keep & fmask);
        fl  = (rem != 0) ? 4'b0001 : 4'b0000;
      end
    end
    return res[31:0];
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    int          emax, r, e;
    logic [31:0] f, s;
    emax = (1 << ew) - 1;
    r    = $urandom_range(0, 9);
    case (r)
      0:       e = 0;
      1:       e = emax;
      2:       e = $urandom_range(1, 20 > emax / 2 ? emax / 2 : 20);
      3:       e = emax - 1 - $urandom_range(0, 3);
      default: e = $urandom_range(emax / 4, (3 * emax) / 4);
    endcase
    f = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & ((32'd1 << mw) - 32'd1));
    s = 32'($urandom_range(0, 1));
    return (s << (ew + mw)) | (32'(e) << mw) | f;
  endfunction

  // Present one operand pair, wait (bounded) for acceptance, queue expectation.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] er, input logic [3:0] ef);
    int n;
    n = 0;
    a = xa;  b = xb;  in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      q.push_back('{res: er, flg: ef});
      pushes++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [31:0] xa, input logic [31:0] xb);
    logic [31:0] er;
    logic [3:0]  ef;
    er = ref_mul(8, 23, xa, xb, ef);
    issue(xa, xb, er, ef);
  endtask

  // Monitor / scoreboard
  logic        was_rst    = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res   = '0;
  exp_t        m_e;
  always begin
    @(negedge clk); #2;
    if (!rst_n) begin
      was_rst    = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (was_rst) check("post_reset_out_valid", 32'(out_valid), 32'd0);
      was_rst = 1'b0;
      if (prev_stall) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_result_hold", result, prev_res);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got result %h, required no output", result);
        end else begin
          m_e = q.pop_front();
          pops++;
          check("result", result, m_e.res);
`ifdef FP_MUL_FLAGS_EN
          check("flags", 32'(flags), 32'(m_e.flg));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
    end
  end

  task automatic h_op(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] er, input logic [3:0] ef);
    int n;
    h_a = x;  h_b = y;  h_in_valid = 1'b1;
    #1;
    check("h_in_ready", 32'(h_in_ready), 32'd1);
    @(negedge clk);
    h_in_valid = 1'b0;
    n = 1;
    while (!h_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!h_out_valid) begin
      checks++;
      errors++;
      $display("FAIL h_timeout: out_valid %b, required 1", h_out_valid);
    end else begin
      check("h_latency", 32'(n), 32'd3);
      check("h_result", 32'(h_result), 32'(er));
`ifdef FP_MUL_FLAGS_EN
      check("h_flags", 32'(h_flags), 32'(ef));
`endif
    end
  endtask

  task automatic h_op_m(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] er;
    logic [3:0]  ef;
    er = ref_mul(5, 10, {16'd0, x}, {16'd0, y}, ef);
    h_op(x, y, er[15:0], ef);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] op0_exp, xa, xb;
    logic [3:0]  op0_flg;
    rst_n = 1'b0;  in_valid = 1'b0;  a = '0;  b = '0;
    h_in_valid = 1'b0;  h_a = '0;  h_b = '0;  h_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: 3.0 x 2.5
    issue(32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle3", 32'(out_valid), 32'd1);
    @(negedge clk);

    // Directed arithmetic and special values
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    issue(32'h3F800001, 32'h3F800000, 32'h3F800001, 4'b0000);
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    issue(32'h3F800000, 32'h80000000, 32'h80000000, 4'b0000);
    issue(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    issue(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    issue(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
    issue(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    issue(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
    issue(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001);
    repeat (5) @(negedge clk);

    // Backpressure: 3 ops fill the pipe, 4th waits while consumer is stalled
    bp_val = 1'b0;
    op0_exp = ref_mul(8, 23, 32'h40400000, 32'h40200000, op0_flg);
    issue(32'h40400000, 32'h40200000, op0_exp, op0_flg);
    issue_m(32'h3FC00000, 32'hC0800000);
    issue_m(32'h42C80000, 32'h3DCCCCCD);
    xa = 32'h41200000;  xb = 32'hBF000000;
    a = xa;  b = xb;  in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_frozen_op0", result, op0_exp);
      @(negedge clk);
    end
    bp_val = 1'b1;
    issue_m(xa, xb);
    repeat (8) @(negedge clk);

    // Reset with two operations in flight
    issue_m(32'h40000000, 32'h40400000);
    issue_m(32'h3F000000, 32'h41000000);
    rst_n = 1'b0;
    dropped += q.size();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_midop_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_after_reset", 32'(out_valid), 32'd0);
    end

    // Randomised traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      issue_m(rand_op(8, 23), rand_op(8, 23));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    rand_bp = 1'b0;
    bp_val  = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("in_order_count", 32'(pops), 32'(pushes - dropped));

    // Half precision
    h_op(16'h3C00, 16'hC000, 16'hC000, 4'b0000);
    h_op(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
    for (int i = 0; i < 30; i++) begin
      h_op_m(rand_op(5, 10)[15:0], rand_op(5, 10)[15:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
